imem_fetch_unit: RTL and testbench
==================================

Name: imem_fetch_unit

Overview:
Parametrised instruction memory for the single-cycle RISC-V core, the successor to the fixed 128-entry ROM. It adds a word-addressed boot-loader write port, a registered fetch request/response handshake with 1-cycle latency, and alignment/range fault reporting. After reset, a clear sequencer fills every word with the canonical NOP before fetches are accepted. Sits between the PC/fetch stage and the decoder; the loader port is driven by the testbench or a future boot ROM.

Parameters:
ADDR_W, 32, width of fetch byte address
DEPTH, 128, number of 32-bit instruction words (power of 2, >=2)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned)
NOP_INSN, 32'h0000_0013, fill value and fault-return value (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
fetch_req  in  1  fetch request, sampled when fetch_ready=1
fetch_addr  in  ADDR_W  byte address of instruction
fetch_ready  out  1  unit accepts fetch this cycle
rsp_valid  out  1  one-cycle pulse, response valid
rsp_insn  out  32  fetched instruction
rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range
load_we  in  1  loader write strobe
load_idx  in  $clog2(DEPTH)+1  word index to write
load_data  in  32  word to write
load_ack  out  1  one-cycle pulse, write completed or rejected
load_err  out  1  valid with load_ack; 1 = index >= DEPTH, no write
init_done  out  1  clear sweep finished

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values: fetch_ready=0, rsp_valid=0, rsp_insn=NOP_INSN, rsp_fault=00, load_ack=0, load_err=0, init_done=0. The FSM enters CLEAR with clr_idx=0.
- FSM CLEAR:
  - Each cycle writes NOP_INSN to mem[clr_idx] and increments clr_idx.
  - After the write of index DEPTH-1, the FSM moves to READY.
  - This takes exactly DEPTH cycles after the first cycle with rst=0. init_done and fetch_ready go 1 on the first READY cycle.
  - In CLEAR, fetch_req and load_we are ignored; no ack and no rsp are produced.
- FSM READY: stays until rst. fetch_ready=1 constantly; there is no backpressure on the response.
- Fetch:
  - A fetch is accepted when fetch_req=1 and fetch_ready=1.
  - The next cycle, rsp_valid=1 with rsp_insn and rsp_fault; otherwise rsp_valid=0. rsp_insn/rsp_fault hold their last values when rsp_valid=0.
  - Back-to-back fetches every cycle give back-to-back responses.
- Address decode:
  - off = fetch_addr - BASE_ADDR (ADDR_W-bit, unsigned).
  - Misaligned if fetch_addr[1:0]!=0.
  - Out of range if fetch_addr < BASE_ADDR or off>>2 >= DEPTH.
  - Misaligned has priority (01) when both apply.
  - On any fault, rsp_insn=NOP_INSN and the memory is not read.
- Loader:
  - Active only in READY. When load_we=1: if load_idx < DEPTH, write mem[load_idx]=load_data; otherwise no write and load_err=1.
  - load_ack pulses the cycle after load_we in every case.
  - load_we held for N cycles gives N writes and N acks.
- Same-cycle load and fetch to the same word: read-first. The response returns the old word; the next fetch sees the new word.
- Reset mid-operation: at the first edge with rst=1, all outputs take reset values. A pending rsp_valid or load_ack is dropped, not delivered. The sweep restarts and all loaded contents are overwritten with NOP.

Decomposition:
- Package imem_pkg: NOP_INSN default, fault codes FAULT_OK/FAULT_MISALIGN/FAULT_RANGE, FSM state enum {CLEAR, READY}.
- Sub-module imem_ram: DEPTH x 32 array, one sync write port, one registered read port (read-first). The clear sweep and the loader are muxed onto its write port, with the clear sweep having priority.
- Top block holds the FSM, address decode and handshake registers.

Test Plan:
- DEPTH=8: release rst at cycle 0 -> init_done=0 for cycles 0-7, init_done=1 and fetch_ready=1 at cycle 8; fetch 0x8 -> rsp_insn=0x00000013, fault=00 one cycle later.
- Load idx1=0x019C06B3 -> load_ack=1, load_err=0 next cycle; fetch 0x4 -> rsp_insn=0x019C06B3, fault=00.
- Fetch 0x6 -> fault=01, insn=NOP; fetch 0x20 (DEPTH=8) -> fault=10, insn=NOP; fetch 0x22 -> fault=01; load idx 8 -> load_ack=1, load_err=1, memory unchanged.
- Same cycle: load idx2=0x40000033 and fetch 0x8 -> rsp_insn=0x00000013; following fetch 0x8 -> 0x40000033.
- Fetch 0x0, 0x4, 0x8, 0xC on consecutive cycles -> four consecutive rsp_valid pulses in order, with no gaps.
- Assert rst in the same cycle as a fetch -> no rsp_valid; fetch_ready=0 for 8 cycles after release; fetch 0x4 -> NOP (prior load erased).

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants for the instruction memory fetch unit.
//   DEFAULT_NOP_INSN : canonical NOP (addi x0,x0,0) used for fill and fault returns
//   FAULT_*          : response fault codes
//   StClear/StReady  : FSM state encodings
package imem_pkg;

  localparam logic [31:0] DEFAULT_NOP_INSN = 32'h0000_0013;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  typedef logic [0:0] state_t;
  localparam state_t StClear = 1'b0;
  localparam state_t StReady = 1'b1;

  // Misalignment wins when an address is both misaligned and out of range.
  function automatic logic [1:0] fault_code(input logic misalign, input logic out_of_range);
    if (misalign) begin
      return FAULT_MISALIGN;
    end else if (out_of_range) begin
      return FAULT_RANGE;
    end else begin
      return FAULT_OK;
    end
  endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction storage.
//   clk, rst        : clock, synchronous active-high reset (read register only)
//   we/waddr/wdata  : synchronous write port
//   re/raddr/rdata  : registered read port; rdata updates only when re=1, read-first
module imem_ram #(
  parameter int unsigned DEPTH      = 128,
  parameter logic [31:0] RESET_DATA = 32'h0000_0013,
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Non-blocking read of mem_q returns the pre-write word on a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= RESET_DATA;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with fetch handshake, boot-loader write port and fault reporting.
//   clk, rst                        : clock, synchronous active-high reset
//   fetch_req/fetch_addr/fetch_ready: fetch request, accepted when both req and ready are high
//   rsp_valid/rsp_insn/rsp_fault    : response one cycle after acceptance; insn/fault hold
//   load_we/load_idx/load_data      : loader word write (READY only)
//   load_ack/load_err               : one-cycle ack after each load strobe; err = index too big
//   init_done                       : NOP clear sweep has finished
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 128,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0]       NOP_INSN  = DEFAULT_NOP_INSN,
  localparam int unsigned      IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_insn,
  output logic [1:0]        rsp_fault,
  input  logic              load_we,
  input  logic [IDX_W:0]    load_idx,
  input  logic [31:0]       load_data,
  output logic              load_ack,
  output logic              load_err,
  output logic              init_done
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             rsp_valid_q;
  logic [1:0]       rsp_fault_q;
  logic             load_ack_q, load_err_q;

  logic [ADDR_W-1:0] off;
  logic              misalign, out_of_range;
  logic [1:0]        fault_d;
  logic              fetch_acc, load_acc, load_bad;
  logic              ram_we, ram_re;
  logic [IDX_W-1:0]  ram_waddr;
  logic [31:0]       ram_wdata, ram_rdata;

  assign fetch_ready = (state_q == StReady);
  assign init_done   = (state_q == StReady);

  // Address decode
  assign off          = fetch_addr - BASE_ADDR;
  assign misalign     = (fetch_addr[1:0] != 2'b00);
  assign out_of_range = (fetch_addr < BASE_ADDR) || ((off >> 2) >= ADDR_W'(DEPTH));
  assign fault_d      = fault_code(misalign, out_of_range);

  assign fetch_acc = fetch_req && fetch_ready;
  assign load_acc  = load_we && (state_q == StReady);
  assign load_bad  = (load_idx >= (IDX_W + 1)'(DEPTH));
  assign ram_re    = fetch_acc && (fault_d == FAULT_OK);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ram_we    = 1'b0;
    ram_waddr = load_idx[IDX_W-1:0];
    ram_wdata = load_data;
    if (state_q == StClear) begin
      // Clear sweep owns the write port until the last word is written.
      ram_we    = 1'b1;
      ram_waddr = clr_idx_q;
      ram_wdata = NOP_INSN;
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
        state_d = StReady;
      end
    end else begin
      ram_we = load_acc && !load_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StClear;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= FAULT_OK;
      load_ack_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rsp_valid_q <= fetch_acc;
      if (fetch_acc) begin
        rsp_fault_q <= fault_d;
      end
      load_ack_q <= load_acc;
      load_err_q <= load_acc && load_bad;
    end
  end

  imem_ram #(
    .DEPTH      (DEPTH),
    .RESET_DATA (NOP_INSN)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (off[IDX_W+1:2]),
    .rdata (ram_rdata)
  );

  // Faulted fetches never read the RAM, so the NOP substitution happens here.
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_insn  = (rsp_fault_q != FAULT_OK) ? NOP_INSN : ram_rdata;
  assign load_ack  = load_ack_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IW    = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        rsp_valid;
  logic [31:0] rsp_insn;
  logic [1:0]  rsp_fault;
  logic        load_we;
  logic [IW:0] load_idx;
  logic [31:0] load_data;
  logic        load_ack;
  logic        load_err;
  logic        init_done;

  int checks   = 0;
  int failures = 0;

  logic [33:0] rsp_q[$];
  logic        ack_q[$];
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  imem_fetch_unit #(
    .ADDR_W    (32),
    .DEPTH     (DEPTH),
    .BASE_ADDR (32'h0),
    .NOP_INSN  (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .rsp_valid   (rsp_valid),
    .rsp_insn    (rsp_insn),
    .rsp_fault   (rsp_fault),
    .load_we     (load_we),
    .load_idx    (load_idx),
    .load_data   (load_data),
    .load_ack    (load_ack),
    .load_err    (load_err),
    .init_done   (init_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {fault, insn} for a fetch, from the bench's own memory image.
  function automatic logic [33:0] expect_fetch(input logic [31:0] addr);
    logic [1:0]  f;
    logic [31:0] insn;
    if (addr[1:0] != 2'b00)        f = 2'b01;
    else if (addr >= 32'(4 * DEPTH)) f = 2'b10;
    else                            f = 2'b00;
    insn = (f != 2'b00) ? NOP : model[addr[IW+1:2]];
    return {f, insn};
  endfunction

  // Advance one edge, then compare outputs against the scoreboard heads.
  task automatic tick();
    logic [33:0] er;
    logic        ee;
    @(posedge clk);
    #1;
    if (rsp_q.size() > 0) begin
      er = rsp_q.pop_front();
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_fault_insn", 64'({rsp_fault, rsp_insn}), 64'(er));
    end else begin
      chk("rsp_idle", 64'(rsp_valid), 64'd0);
    end
    if (ack_q.size() > 0) begin
      ee = ack_q.pop_front();
      chk("load_ack", 64'(load_ack), 64'd1);
      chk("load_err", 64'(load_err), 64'(ee));
    end else begin
      chk("load_idle", 64'(load_ack), 64'd0);
    end
  endtask

  task automatic step(input logic do_f, input logic [31:0] addr,
                      input logic do_l, input logic [IW:0] idx, input logic [31:0] data);
    fetch_req  = do_f;
    fetch_addr = addr;
    load_we    = do_l;
    load_idx   = idx;
    load_data  = data;
    if (do_f) rsp_q.push_back(expect_fetch(addr));
    if (do_l) begin
      ack_q.push_back(idx >= (IW + 1)'(DEPTH));
      if (idx < (IW + 1)'(DEPTH)) model[idx[IW-1:0]] = data;
    end
    tick();
    fetch_req = 1'b0;
    load_we   = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_we    = 1'b0;
    load_idx   = '0;
    load_data  = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;

    tick();
    tick();
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_rsp_insn", 64'(rsp_insn), 64'(NOP));
    chk("rst_rsp_fault", 64'(rsp_fault), 64'd0);
    chk("rst_load_err", 64'(load_err), 64'd0);

    // Clear sweep: requests during CLEAR must be ignored.
    rst        = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    load_we    = 1'b1;
    load_idx   = 4'd1;
    load_data  = 32'hdead_beef;
    for (int c = 0; c < DEPTH; c++) begin
      chk("clear_init_done", 64'(init_done), 64'd0);
      chk("clear_fetch_ready", 64'(fetch_ready), 64'd0);
      tick();
    end
    fetch_req = 1'b0;
    load_we   = 1'b0;
    chk("ready_init_done", 64'(init_done), 64'd1);
    chk("ready_fetch_ready", 64'(fetch_ready), 64'd1);

    step(1'b1, 32'h8, 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, 4'd1, 32'h019C_06B3);
    step(1'b1, 32'h4, 1'b0, '0, '0);
    step(1'b1, 32'h6, 1'b0, '0, '0);
    step(1'b1, 32'h20, 1'b0, '0, '0);
    step(1'b1, 32'h22, 1'b0, '0, '0);
    step(1'b1, 32'hFFFF_FFFC, 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, 4'd8, 32'h1234_5678);
    step(1'b1, 32'h0, 1'b0, '0, '0);
    // Back-to-back loads, then same-cycle load/fetch (read-first).
    step(1'b0, '0, 1'b1, 4'd3, 32'h0020_8133);
    step(1'b0, '0, 1'b1, 4'd7, 32'h0041_01B3);
    step(1'b1, 32'h8, 1'b1, 4'd2, 32'h4000_0033);
    step(1'b1, 32'h8, 1'b0, '0, '0);
    // Consecutive fetches with no gaps.
    step(1'b1, 32'h0, 1'b0, '0, '0);
    step(1'b1, 32'h4, 1'b0, '0, '0);
    step(1'b1, 32'h8, 1'b0, '0, '0);
    step(1'b1, 32'hC, 1'b0, '0, '0);
    step(1'b1, 32'h1C, 1'b0, '0, '0);
    tick();
    chk("hold_insn", 64'(rsp_insn), 64'(model[7]));

    // Reset together with a fetch: no response, sweep restarts, loads erased.
    step(1'b1, 32'h4, 1'b0, '0, '0);
    rst        = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    tick();
    fetch_req = 1'b0;
    rst       = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    chk("rerst_rsp_insn", 64'(rsp_insn), 64'(NOP));
    for (int c = 0; c < DEPTH; c++) begin
      chk("reclear_fetch_ready", 64'(fetch_ready), 64'd0);
      tick();
    end
    chk("reready_init_done", 64'(init_done), 64'd1);
    step(1'b1, 32'h4, 1'b0, '0, '0);
    step(1'b1, 32'h8, 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
